// File: rtl/lookup_arbiter.sv
// Round-robin arbiter sharing one flow-table lookup engine among NREQ forwarders.
// Optional watchdog on stalled lookups: define LOOKUP_ARB_TIMEOUT_EN.
module lookup_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DATA_W  = 116,
  parameter int unsigned PORT_W  = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NREQ-1:0]          req_lookup_req,
  input  logic [NREQ*DATA_W-1:0]   req_lookup_data,
  output logic [NREQ-1:0]          req_lookup_ack,
  output logic [NREQ-1:0]          req_lookup_err,
  output logic [PORT_W-1:0]        req_lookup_fwd_port,
  output logic                     of_lookup_req,
  output logic [DATA_W-1:0]        of_lookup_data,
  input  logic                     of_lookup_ack,
  input  logic                     of_lookup_err,
  input  logic [PORT_W-1:0]        of_lookup_fwd_port
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   gnt_q;
  logic [NREQ-1:0]   ack_q;
  logic [NREQ-1:0]   err_q;
  logic [PORT_W-1:0] fwd_port_q;
  logic              of_req_q;
  logic [DATA_W-1:0] of_data_q;

  // First requesting index at or after rr_ptr, wrapping modulo NREQ.
  logic            pick_found;
  logic [IdxW-1:0] pick_idx;

  always_comb begin
    int unsigned j;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_found && req_lookup_req[j]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(j);
      end
    end
  end

  logic [IdxW-1:0] gnt_next;
  assign gnt_next = (gnt_q == IdxW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;

  logic timeout_hit;
`ifdef LOOKUP_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;
  assign timeout_hit = (state_q == StBusy) && (cnt_q == CntW'(TIMEOUT));

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt_q <= '0;
    end else if (state_q == StBusy) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      fwd_port_q <= '0;
      of_req_q   <= 1'b0;
      of_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            gnt_q     <= pick_idx;
            of_data_q <= req_lookup_data[pick_idx*DATA_W +: DATA_W];
            of_req_q  <= 1'b1;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (of_lookup_ack || of_lookup_err || timeout_hit) begin
            of_req_q <= 1'b0;
            rr_ptr_q <= gnt_next;
            state_q  <= StRelease;
            // Error (including watchdog) takes priority over a coincident ack.
            if (of_lookup_err || timeout_hit) begin
              err_q      <= NREQ'(1) << gnt_q;
              fwd_port_q <= '0;
            end else begin
              ack_q      <= NREQ'(1) << gnt_q;
              fwd_port_q <= of_lookup_fwd_port;
            end
          end
        end
        StRelease: begin
          // No arbitration here so the just-served requester's stale req is skipped.
          ack_q      <= '0;
          err_q      <= '0;
          fwd_port_q <= '0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_lookup_ack      = ack_q;
  assign req_lookup_err      = err_q;
  assign req_lookup_fwd_port = fwd_port_q;
  assign of_lookup_req       = of_req_q;
  assign of_lookup_data      = of_data_q;

endmodule
